div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. The execute stage starts it and holds the pipeline stalled while it runs. The divider returns a 64-bit {remainder, quotient} with a ready handshake, which execute then writes to HI/LO. It is the responder to execute's stall-and-recirculate initiator: it resolves a division over 32+ cycles while the upstream pipeline registers hold still.

## Interface

- No parameters; datapath fixed at 32-bit operands and 64-bit result.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request. Execute holds it high from issue until it has consumed ready_o.
- annul_i  in  1  abort the current divide, e.g. on pipeline flush.
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1.
- ready_o  out  1  result valid.

## Operation

- States: IDLE, BYZERO, ON, END.
- Reset: state IDLE, result_o = 0, ready_o = 0, iteration counter = 0.
- **IDLE**
  - If start_i = 1 and annul_i = 0:
    - opdata2_i = 0 → go to BYZERO.
    - Otherwise → go to ON with counter = 0.
    - Operands are latched on this edge. When signed, each negative operand is replaced by its two's-complement magnitude (0x80000000 stays 0x80000000, read as unsigned).
  - Otherwise: result_o = 0, ready_o = 0.
- **BYZERO**: force quotient and remainder to 0, go to END.
- **ON**
  - annul_i = 1 → go to IDLE immediately, result discarded, ready_o stays 0.
  - Otherwise perform one restoring-division step per cycle on a 65-bit shift register:
    - Trial subtract: upper 33 bits minus {0, divisor}.
    - Non-negative → keep the difference and shift in quotient bit 1.
    - Negative → shift only and shift in quotient bit 0.
    - Increment the counter.
  - On the edge where counter = 32, apply the sign fix and go to END:
    - Signed, operand signs differ → negate the quotient.
    - Signed, dividend negative → negate the remainder.
    - Load result_o and set ready_o = 1.
- **END**
  - ready_o = 1 and result_o are held while start_i = 1.
  - start_i = 0 → go to IDLE, ready_o = 0, result_o = 0.
- annul_i in IDLE, BYZERO or END: no effect beyond the rules above.
- Signed overflow 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps, no trap).
- Arithmetic is modulo 2^32 per half. Quotient truncates toward zero; the remainder takes the dividend's sign.

## Timing

- Edges are counted with edge 1 = the edge that samples start_i = 1 in IDLE.
- Nonzero divisor: ready_o is high after edge 34, i.e. edge 1 enters ON, edges 2–33 run 32 iterations, edge 34 loads the result.
- Zero divisor: ready_o is high after edge 3 (edge 1 → BYZERO, edge 2 → END with result 0). ready_o must be registered, so it rises one cycle after END is entered.
- ready_o is registered and never combinationally dependent on the inputs.
- Operand inputs are ignored after edge 1; execute may change them freely.
- After start_i drops in END, ready_o = 0 after the next edge. A new start_i is accepted on the following edge (from IDLE).
- rst = 1 at any edge, including mid-ON, returns all state and outputs to reset values on that edge.

## Configuration

- Macro **DIV_SIGNED_EN**.
- Defined: signed_div_i is honored (magnitude conversion plus sign fix-up as above).
- Undefined: signed_div_i is ignored and every divide is unsigned. The sign-conversion logic is not built; IDLE → ON latency is unchanged.

## Test plan

- Unsigned 100 / 7: ready_o rises after edge 34 and result_o = 0x00000002_0000000E.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) with DIV_SIGNED_EN: result_o = 0xFFFFFFFF_FFFFFFFD. The same operands with the macro undefined give the unsigned result 0x00000001_7FFFFFFC.
- Divide by zero, 1234 / 0: ready_o rises after edge 3 and result_o = 0.
- Annul: start 0xFFFFFFFF / 3, assert annul_i for one cycle at edge 10. ready_o never rises and the block is back in IDLE. A following 9 / 3 returns 0x00000000_00000003 after 34 edges.
- Handshake hold: keep start_i high 5 cycles past ready_o; result_o stays stable throughout. Drop start_i; ready_o and result_o go to 0 after the next edge.
- Reset mid-operation: assert rst at edge 20 of 0x80000000 / 0xFFFFFFFF (signed). Outputs go to 0 on that edge. A rerun after release yields 0x00000000_80000000.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU; result {remainder, quotient} with ready handshake.
// Define DIV_SIGNED_EN to honor signed_div_i; otherwise every divide is unsigned.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

    state_e      state_q, state_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] op1_abs, op2_abs;
    logic [31:0] quot_fix, rem_fix;
    logic [64:0] shifted;
    logic [33:0] diff;

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;

    // 0x80000000 negates to itself and is then read as an unsigned magnitude
    assign op1_abs  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    assign quot_fix = neg_quot_q ? (~dividend_q[31:0] + 32'd1) : dividend_q[31:0];
    assign rem_fix  = neg_rem_q ? (~dividend_q[63:32] + 32'd1) : dividend_q[63:32];
`else
    logic unused_signed;

    assign unused_signed = signed_div_i;
    assign op1_abs       = opdata1_i;
    assign op2_abs       = opdata2_i;
    assign quot_fix      = dividend_q[31:0];
    assign rem_fix       = dividend_q[63:32];
`endif

    // Shift first, then trial-subtract the divisor from the upper 33 bits
    assign shifted = {dividend_q[63:0], 1'b0};
    assign diff    = {1'b0, shifted[64:32]} - {2'b00, divisor_q};

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        ready_d    = ready_q;
`ifdef DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    dividend_d = {33'd0, op1_abs};
                    divisor_d  = op2_abs;
                    cnt_d      = 6'd0;
`ifdef DIV_SIGNED_EN
                    neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_d  = signed_div_i && opdata1_i[31];
`endif
                    state_d    = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                state_d  = S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q == 6'd32) begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end else begin
                    dividend_d = diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
                    cnt_d      = cnt_q + 6'd1;
                end
            end
            S_END: begin
                // Divide-by-zero reaches here with ready low; it rises on the next edge
                if (start_i) begin
                    ready_d = 1'b1;
                end else begin
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dividend_q <= 65'd0;
            divisor_q  <= 32'd0;
            cnt_q      <= 6'd0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit; expected values hand-computed, signed cases follow DIV_SIGNED_EN.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a divide, scramble operands after edge 1, expect ready exactly after edge lat,
    // hold start for hold extra cycles, then drop it.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input logic [63:0] exp,
                           input int hold);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        for (int e = 1; e <= lat; e++) begin
            tick;
            if (e == 1) begin
                opdata1_i    = ~a;
                opdata2_i    = b ^ 32'h0000_0005;
                signed_div_i = ~sgn;
            end
            if (e == lat - 1)
                check($sformatf("%s_early_ready", tag), {63'd0, ready_o}, 64'd0);
        end
        check($sformatf("%s_ready", tag), {63'd0, ready_o}, 64'd1);
        check($sformatf("%s_result", tag), result_o, exp);
        for (int h = 0; h < hold; h++) begin
            tick;
            check($sformatf("%s_hold_ready%0d", tag, h), {63'd0, ready_o}, 64'd1);
            check($sformatf("%s_hold_result%0d", tag, h), result_o, exp);
        end
        start_i = 1'b0;
        tick;
        check($sformatf("%s_drop_ready", tag), {63'd0, ready_o}, 64'd0);
        check($sformatf("%s_drop_result", tag), result_o, 64'd0);
    endtask

    initial begin
        logic [63:0] exp_neg7, exp_7n2, exp_n8n3, exp_ovf;
        logic        seen;

`ifdef DIV_SIGNED_EN
        exp_neg7 = 64'hFFFFFFFF_FFFFFFFD;
        exp_7n2  = 64'h00000001_FFFFFFFD;
        exp_n8n3 = 64'hFFFFFFFE_00000002;
        exp_ovf  = 64'h00000000_80000000;
`else
        exp_neg7 = 64'h00000001_7FFFFFFC;
        exp_7n2  = 64'h00000007_00000000;
        exp_n8n3 = 64'hFFFFFFF8_00000000;
        exp_ovf  = 64'h80000000_00000000;
`endif

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        tick;
        tick;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        tick;

        run_div("u100_7",   1'b0, 32'd100,      32'd7,        34, 64'h00000002_0000000E, 0);
        run_div("s_neg7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 34, exp_neg7, 0);
        run_div("div0",     1'b0, 32'd1234,     32'd0,        3,  64'd0, 2);
        run_div("hold",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 64'h00000000_00000001, 5);
        run_div("u5_10",    1'b0, 32'd5,        32'd10,       34, 64'h00000005_00000000, 0);
        run_div("s7_n2",    1'b1, 32'd7,        32'hFFFFFFFE, 34, exp_7n2, 0);
        run_div("sn8_n3",   1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 34, exp_n8n3, 0);

        // Annul at edge 10; execute drops start on the same flush
        signed_div_i = 1'b0;
        opdata1_i    = 32'hFFFFFFFF;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        for (int e = 1; e <= 9; e++) tick;
        annul_i = 1'b1;
        start_i = 1'b0;
        tick;
        annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (ready_o) seen = 1'b1;
        end
        check("annul_no_ready", {63'd0, seen}, 64'd0);
        check("annul_result", result_o, 64'd0);
        run_div("after_annul", 1'b0, 32'd9, 32'd3, 34, 64'h00000000_00000003, 0);

        // Synchronous reset at edge 20 of the signed overflow case, then rerun it
        signed_div_i = 1'b1;
        opdata1_i    = 32'h80000000;
        opdata2_i    = 32'hFFFFFFFF;
        start_i      = 1'b1;
        for (int e = 1; e <= 19; e++) tick;
        rst     = 1'b1;
        start_i = 1'b0;
        tick;
        check("midrst_ready", {63'd0, ready_o}, 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst = 1'b0;
        tick;
        run_div("ovf_rerun", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, exp_ovf, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
